// File: rtl/fdiv_iter.sv
// fdiv_iter: multi-cycle IEEE-754-style divider y = x1 / x2.
// Radix-2 restoring mantissa division, round-to-nearest-even, denormals flushed to zero.
// One operation in flight; valid/ready handshake on both sides.
module fdiv_iter #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   x1,
  input  logic [EXP_W+MAN_W:0]   x2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   y,
  output logic [3:0]             flags
);

  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned EW = EXP_W + 2;          // signed working exponent
  localparam int unsigned MW = MAN_W + 2;          // remainder / quotient width
  localparam int unsigned CW = $clog2(MAN_W + 2);  // iteration counter

  localparam logic [EW-1:0]        BIAS_V  = EW'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX_V  = EW'((2 ** EXP_W) - 1);
  localparam logic signed [EW-1:0] ONE_V   = EW'(1);
  localparam logic [CW-1:0]        LAST_IT = CW'(MAN_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_SPECIAL,
    S_ROUND,
    S_DONE
  } state_t;

  state_t                 state;
  logic                   sign_q;
  logic signed [EW-1:0]   exp_q;
  logic [MW-1:0]          rem_q;
  logic [MAN_W:0]         div_q;
  logic [MW-1:0]          quo_q;
  logic [CW-1:0]          cnt_q;

  // Operand decode
  logic               s1, s2, sgn;
  logic [EXP_W-1:0]   e1, e2;
  logic [MAN_W-1:0]   f1, f2;
  logic               nan1, nan2, inf1, inf2, zero1, zero2;
  logic [MAN_W:0]     man1, man2;
  logic               lt;
  logic [MW-1:0]      dvd_start;
  logic signed [EW-1:0] e_start;

  assign s1    = x1[W-1];
  assign s2    = x2[W-1];
  assign e1    = x1[W-2:MAN_W];
  assign e2    = x2[W-2:MAN_W];
  assign f1    = x1[MAN_W-1:0];
  assign f2    = x2[MAN_W-1:0];
  assign sgn   = s1 ^ s2;
  assign nan1  = (&e1) & (|f1);
  assign nan2  = (&e2) & (|f2);
  assign inf1  = (&e1) & ~(|f1);
  assign inf2  = (&e2) & ~(|f2);
  assign zero1 = ~(|e1);
  assign zero2 = ~(|e2);

  // Pre-normalise so the quotient always lands in [1,2)
  assign man1      = {1'b1, f1};
  assign man2      = {1'b1, f2};
  assign lt        = man1 < man2;
  assign dvd_start = lt ? {man1, 1'b0} : {1'b0, man1};
  assign e_start   = $signed({2'b00, e1} - {2'b00, e2} + BIAS_V - EW'(lt));

  // Special-case result selection in priority order
  logic           sp_hit;
  logic [W-1:0]   sp_y;
  logic [3:0]     sp_flags;

  always_comb begin
    sp_hit   = 1'b1;
    sp_y     = '0;
    sp_flags = '0;
    if (nan1 | nan2 | (zero1 & zero2) | (inf1 & inf2)) begin
      sp_y     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      sp_flags = 4'b1000;
    end else if (inf1) begin
      sp_y = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (inf2) begin
      sp_y = {sgn, {(W-1){1'b0}}};
    end else if (zero2) begin
      sp_y     = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      sp_flags = 4'b0100;
    end else if (zero1) begin
      sp_y = {sgn, {(W-1){1'b0}}};
    end else begin
      sp_hit = 1'b0;
    end
  end

  // One restoring-division step
  logic [MW-1:0] div_ext, rem_sub, rem_shift;
  logic          rem_ge;

  assign div_ext   = {1'b0, div_q};
  assign rem_ge    = rem_q >= div_ext;
  assign rem_sub   = rem_ge ? (rem_q - div_ext) : rem_q;
  assign rem_shift = {rem_sub[MW-2:0], 1'b0};

  // Round-to-nearest-even and exponent range check
  logic [MAN_W:0]       mant;
  logic                 guard, sticky, round_up, carry;
  logic [MW-1:0]        mant_r;
  logic [MAN_W-1:0]     frac_r;
  logic signed [EW-1:0] exp_r;
  logic [W-1:0]         nrm_y;
  logic [3:0]           nrm_flags;

  assign mant     = quo_q[MW-1:1];
  assign guard    = quo_q[0];
  assign sticky   = |rem_q;
  assign round_up = guard & (sticky | mant[0]);
  assign mant_r   = {1'b0, mant} + MW'(round_up);
  assign carry    = mant_r[MW-1];
  assign frac_r   = carry ? '0 : mant_r[MAN_W-1:0];
  assign exp_r    = exp_q + EW'(carry);

  always_comb begin
    nrm_y     = {sign_q, exp_r[EXP_W-1:0], frac_r};
    nrm_flags = '0;
    if (exp_r >= EMAX_V) begin
      nrm_y     = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      nrm_flags = 4'b0010;
    end else if (exp_r < ONE_V) begin
      nrm_y     = {sign_q, {(W-1){1'b0}}};
      nrm_flags = 4'b0001;
    end
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= '0;
      flags     <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            sign_q   <= sgn;
            exp_q    <= e_start;
            rem_q    <= dvd_start;
            div_q    <= man2;
            quo_q    <= '0;
            cnt_q    <= '0;
            if (sp_hit) begin
              y     <= sp_y;
              flags <= sp_flags;
              state <= S_SPECIAL;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_q <= rem_shift;
          quo_q <= {quo_q[MW-2:0], rem_ge};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_IT) state <= S_ROUND;
        end
        S_ROUND: begin
          y         <= nrm_y;
          flags     <= nrm_flags;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_SPECIAL: begin
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_iter.sv
// tb_fdiv_iter: directed and randomized checks of fdiv_iter (binary32 defaults).
module tb_fdiv_iter;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] x1, x2, y;
  logic [3:0]  flags;
  int          checks = 0;
  int          errors = 0;

  localparam int NORM_LAT = 27;
  localparam int SPEC_LAT = 2;

  always #5 clk = ~clk;

  fdiv_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .flags(flags)
  );

  // Directed vectors: dividend, divisor, quotient, flags, latency
  localparam logic [31:0] DA [9] = '{32'h40400000, 32'h437f0000, 32'h4048f5c3, 32'h3f800000,
                                     32'h7f000000, 32'h00800000, 32'h3f800000, 32'h00000000,
                                     32'h7f800000};
  localparam logic [31:0] DB [9] = '{32'h40000000, 32'hc37f0000, 32'h40000000, 32'h3f8ccccd,
                                     32'h3f000000, 32'h40000000, 32'h00000000, 32'h00000000,
                                     32'h7f800000};
  localparam logic [31:0] DY [9] = '{32'h3fc00000, 32'hbf800000, 32'h3fc8f5c3, 32'h3f68ba2e,
                                     32'h7f800000, 32'h00000000, 32'h7f800000, 32'h7fc00000,
                                     32'h7fc00000};
  localparam logic [3:0]  DF [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                     4'b0010, 4'b0001, 4'b0100, 4'b1000, 4'b1000};
  localparam int          DL [9] = '{27, 27, 27, 27, 27, 27, 2, 2, 2};

  // Reference: {is_special, flags, y} from exact integer quotient and remainder
  function automatic logic [36:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic       sg;
    logic [7:0] ea, eb;
    logic [22:0] fa, fb;
    bit         nan_a, nan_b, inf_a, inf_b, zer_a, zer_b;
    longint     ma, mb, num, q, r;
    int         e;
    sg = a[31] ^ b[31];
    ea = a[30:23]; eb = b[30:23];
    fa = a[22:0];  fb = b[22:0];
    nan_a = (ea == 8'hff) && (fa != 0);
    nan_b = (eb == 8'hff) && (fb != 0);
    inf_a = (ea == 8'hff) && (fa == 0);
    inf_b = (eb == 8'hff) && (fb == 0);
    zer_a = (ea == 8'h00);
    zer_b = (eb == 8'h00);
    if (nan_a || nan_b || (zer_a && zer_b) || (inf_a && inf_b)) return {1'b1, 4'b1000, 32'h7fc00000};
    if (inf_a) return {1'b1, 4'b0000, sg, 8'hff, 23'h0};
    if (inf_b) return {1'b1, 4'b0000, sg, 31'h0};
    if (zer_b) return {1'b1, 4'b0100, sg, 8'hff, 23'h0};
    if (zer_a) return {1'b1, 4'b0000, sg, 31'h0};
    ma = longint'({1'b1, fa});
    mb = longint'({1'b1, fb});
    e  = int'(ea) - int'(eb) + 127;
    if (ma >= mb) num = ma << 23;
    else begin
      num = ma << 24;
      e   = e - 1;
    end
    q = num / mb;
    r = num % mb;
    if ((2 * r > mb) || ((2 * r == mb) && (q % 2 == 1))) q = q + 1;
    if (q == 64'sd16777216) begin
      q = 64'sd8388608;
      e = e + 1;
    end
    if (e >= 255) return {1'b0, 4'b0010, sg, 8'hff, 23'h0};
    if (e <= 0)   return {1'b0, 4'b0001, sg, 31'h0};
    return {1'b0, 4'b0000, sg, 8'(e), 23'(q)};
  endfunction

  function automatic logic [31:0] gen_operand();
    logic [31:0] sp [7] = '{32'h00000000, 32'h80000000, 32'h7f800000, 32'hff800000,
                             32'h7fc00000, 32'h7f800001, 32'h00000001};
    case ($urandom_range(0, 7))
      0:       return $urandom;
      1:       return sp[$urandom_range(0, 6)];
      2:       return {1'($urandom), 8'($urandom_range(1, 20)), 23'($urandom)};
      3:       return {1'($urandom), 8'($urandom_range(235, 254)), 23'($urandom)};
      default: return {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one operation and collect result, flags and accept-to-valid edge count
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] ry, output logic [3:0] rf, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    in_valid = 1'b1; x1 = a; x2 = b;
    tick();
    in_valid = 1'b0; x1 = $urandom; x2 = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    ry = y; rf = flags;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x1 = '0; x2 = '0;
    tick(); tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (y !== 32'h0) begin errors++; $display("FAIL reset_y got %h want 0", y); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags got %b want 0000", flags); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [31:0] ry;
    logic [3:0]  rf;
    int          lat;
    for (int i = 0; i < 9; i++) begin
      run_op(DA[i], DB[i], ry, rf, lat);
      checks++; if (ry !== DY[i]) begin errors++; $display("FAIL dir%0d_y %h/%h got %h want %h", i, DA[i], DB[i], ry, DY[i]); end
      checks++; if (rf !== DF[i]) begin errors++; $display("FAIL dir%0d_flags got %b want %b", i, rf, DF[i]); end
      checks++; if (lat !== DL[i]) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, DL[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, ry;
    logic [3:0]  rf;
    logic [36:0] exp_v;
    int          lat, want_lat;
    for (int i = 0; i < 80; i++) begin
      a = gen_operand();
      b = gen_operand();
      exp_v = ref_div(a, b);
      want_lat = exp_v[36] ? SPEC_LAT : NORM_LAT;
      run_op(a, b, ry, rf, lat);
      checks++; if (ry !== exp_v[31:0]) begin errors++; $display("FAIL rnd%0d_y %h/%h got %h want %h", i, a, b, ry, exp_v[31:0]); end
      checks++; if (rf !== exp_v[35:32]) begin errors++; $display("FAIL rnd%0d_flags %h/%h got %b want %b", i, a, b, rf, exp_v[35:32]); end
      checks++; if (lat !== want_lat) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, want_lat); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, ry;
    logic [3:0]  rf;
    logic [36:0] exp_v;
    int          n;
    a = {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
    b = {1'b1, 8'($urandom_range(100, 150)), 23'($urandom)};
    exp_v = ref_div(a, b);
    n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    in_valid = 1'b1; x1 = a; x2 = b;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 200) begin tick(); n++; end
    checks++; if (n !== NORM_LAT) begin errors++; $display("FAIL bp_latency got %0d want %0d", n, NORM_LAT); end
    // Offer a new op while stalled; it must not be taken
    in_valid = 1'b1; x1 = 32'h3f800000; x2 = 32'h40000000;
    for (int i = 0; i < 10; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp%0d_out_valid got %b want 1", i, out_valid); end
      checks++; if (y !== exp_v[31:0]) begin errors++; $display("FAIL bp%0d_y got %h want %h", i, y, exp_v[31:0]); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp%0d_in_ready got %b want 0", i, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    run_op(32'h40400000, 32'h40000000, ry, rf, n);
    checks++; if (ry !== 32'h3fc00000) begin errors++; $display("FAIL bp_next_y got %h want 3fc00000", ry); end
    checks++; if (rf !== 4'h0) begin errors++; $display("FAIL bp_next_flags got %b want 0000", rf); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ry;
    logic [3:0]  rf;
    int          lat, n;
    n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    in_valid = 1'b1; x1 = 32'h3f800000; x2 = 32'h3f8ccccd;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
    checks++; if (y !== 32'h0) begin errors++; $display("FAIL rstmid_y got %h want 0", y); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL rstmid_flags got %b want 0000", flags); end
    rst = 1'b0;
    run_op(32'h40200000, 32'h40000000, ry, rf, lat);
    checks++; if (ry !== 32'h3fa00000) begin errors++; $display("FAIL rstmid_next_y got %h want 3fa00000", ry); end
    checks++; if (rf !== 4'h0) begin errors++; $display("FAIL rstmid_next_flags got %b want 0000", rf); end
    checks++; if (lat !== NORM_LAT) begin errors++; $display("FAIL rstmid_next_latency got %0d want %0d", lat, NORM_LAT); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
